uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver stage directly behind the board RX pin inside the UART top.
- Synchronises the asynchronous `rx` line, detects and validates the start bit, and samples 8N1 frames at mid-bit using 16x oversampling.
- Presents each received byte on a valid/ready handshake to downstream consumers: loopback path, display, FIFO.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, sample ticks per bit.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last accepted byte, stable while rx_valid=1.
- rx_valid  output  1  byte available; held until handshake.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte completed while the previous one is still unaccepted.

Behaviour:
- Reset (rst=0), asynchronous:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Both synchroniser flops=1, state=IDLE, all counters=0.
  - Reset mid-frame discards the partial byte.
- Synchroniser: 2 flops on rx, plus a third flop holding the previous synced value for edge detection.
- Tick generator: divisor DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); tick is a one-cycle pulse every DIV clocks, free-running.
- sample counter s, 0..OVERSAMPLE-1, advances on tick; bit counter b, 0..DATA_BITS-1.
- IDLE:
  - Exits only on a synced falling edge (prev=1, now=0), so a held-low line (break) never retriggers.
  - On the edge: s=0, go to START.
- START:
  - On the tick where s=OVERSAMPLE/2-1 (mid start bit), sample.
  - Sample 0: s=0, b=0, go to DATA.
  - Sample 1 (glitch): go to IDLE, no flags.
- DATA:
  - On the tick where s=OVERSAMPLE-1: shift the sample into the MSB of the shift register (LSB-first reception), s wraps to 0.
  - After bit DATA_BITS-1, go to STOP.
- STOP, on the tick where s=OVERSAMPLE-1:
  - Sample 1, valid frame: when rx_valid=0, or rx_valid=1 & rx_ready=1 in the same cycle, load rx_data and set rx_valid=1 next cycle.
  - Sample 1 with rx_valid=1 & rx_ready=0: drop the new byte, keep the old rx_data and rx_valid, pulse overrun.
  - Sample 0: pulse frame_err, byte discarded, rx_valid unchanged.
  - All cases return to IDLE.
- Handshake: rx_valid clears on the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle, in which case it stays 1 with the new data.
- Latency: rx_valid rises 1 clk after the mid-stop sample tick, about 2 + 9.5 bit times after the start edge at the pin.
- frame_err and overrun are never asserted together.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Default constants OVERSAMPLE and DATA_BITS.
  - Divisor function calc_div(clk_freq, baud, os).
- Sub-module uart_baud_tick: parameterised divisor, clk/rst, tick output. Shared with the transmitter.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, giving DIV=10 and a bit time of 160 clk.
1. Send 0xA5 as 8N1 with rx_ready=1 -> rx_valid one-cycle pulse with rx_data=0xA5, 1520±20 clk after the start edge; frame_err=0, overrun=0.
2. Send 0x3C then 0x81 back-to-back with rx_ready=0 -> first byte: rx_valid=1, rx_data=0x3C held. End of second frame: overrun pulses once, rx_data stays 0x3C. Raise rx_ready -> rx_valid clears next cycle.
3. Send 0x55 with the stop bit forced 0 -> frame_err one-cycle pulse, rx_valid stays 0. Line then held low 2000 clk -> no further activity. Release line, send 0x12 -> 0x12 received.
4. 40-clk low glitch on idle line -> returns to IDLE, rx_valid=0, no flags. A following 0xF0 is received correctly.
5. Assert rst=0 during data bit 4 of 0xFF, release after 5 clk, then send 0x0F -> all outputs 0 during reset, only 0x0F delivered.
6. Baud skew: transmit 0x69 at BAUD ±3% -> correct byte, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver and the baud tick generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    // Rounded clock divisor for one oversample tick
    function automatic int calc_div(
        input int clk_freq,
        input int baud,
        input int os
    );
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
// Emits a one-cycle pulse every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling,
// valid/ready output, framing and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic sync1;
    logic sync2;
    logic prev;
    logic fall;
    logic tick;

    rx_state_t state;
    rx_state_t state_next;

    logic [SW-1:0]        s_q;
    logic [SW-1:0]        s_next;
    logic [BW-1:0]        b_q;
    logic [BW-1:0]        b_next;
    logic [DATA_BITS-1:0] sh_q;
    logic [DATA_BITS-1:0] sh_next;
    logic                 load;
    logic                 fe_set;
    logic                 ov_set;
    logic                 mid_start;
    logic                 bit_end;
    logic                 last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edge-only trigger: a line held low never restarts a frame
    assign fall = prev & ~sync2;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign mid_start = tick && (s_q == SW'(OVERSAMPLE / 2 - 1));
    assign bit_end   = tick && (s_q == SW'(OVERSAMPLE - 1));
    assign last_bit  = (b_q == BW'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fall) state_next = START;
            end
            START: begin
                if (mid_start) state_next = sync2 ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        s_next  = s_q;
        b_next  = b_q;
        sh_next = sh_q;
        load    = 1'b0;
        fe_set  = 1'b0;
        ov_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) s_next = '0;
            end
            START: begin
                if (mid_start) begin
                    s_next = '0;
                    b_next = '0;
                end else if (tick) begin
                    s_next = s_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    s_next  = '0;
                    sh_next = {sync2, sh_q[DATA_BITS-1:1]};
                    if (!last_bit) b_next = b_q + 1'b1;
                end else if (tick) begin
                    s_next = s_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    s_next = '0;
                    if (!sync2) begin
                        fe_set = 1'b1;
                    end else if (!rx_valid || rx_ready) begin
                        load = 1'b1;
                    end else begin
                        ov_set = 1'b1;
                    end
                end else if (tick) begin
                    s_next = s_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s_q       <= s_next;
            b_q       <= b_next;
            sh_q      <= sh_next;
            frame_err <= fe_set;
            overrun   <= ov_set;
            if (load) begin
                rx_data  <= sh_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV=10,
// one bit time = 160 clk.
module tb_uart_rx;

    localparam int BT = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int rd = 0;
    int hs_cyc = 0;
    int vld_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int fe_wide = 0;
    int ov_wide = 0;
    logic fe_last = 1'b0;
    logic ov_last = 1'b0;

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) vld_cyc++;
        if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            hs_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (frame_err && fe_last) fe_wide++;
        if (overrun && ov_last) ov_wide++;
        fe_last = frame_err;
        ov_last = overrun;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int bt);
        hold(1'b0, bt);
        for (int i = 0; i < 8; i++) hold(d[i], bt);
        hold(stop, bt);
    endtask

    task automatic wait_got(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() > rd) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_cmp(input string name);
        bit ok;
        logic [7:0] e;
        logic [7:0] g;
        wait_got(3000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: got no byte want one", name);
        end else begin
            e = exp_q.pop_front();
            g = got_q[rd];
            rd++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s_data: got %h want %h", name, g, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b want 0", rx_valid);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h want 00", rx_data);
        end
        checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00", {frame_err, overrun});
        end
        rst = 1'b1;
        hold(1'b1, 50);
    endtask

    task automatic test_single();
        int t0;
        int v0;
        int f0;
        int o0;
        int lat;
        rx_ready = 1'b1;
        v0 = vld_cyc;
        f0 = fe_cnt;
        o0 = ov_cnt;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send(8'hA5, 1'b1, BT);
        pop_cmp("single");
        lat = hs_cyc - t0;
        checks++;
        if (lat < 1500 || lat > 1540) begin
            failures++;
            $display("FAIL single_latency: got %0d want 1500..1540", lat);
        end
        checks++;
        if (vld_cyc - v0 !== 1) begin
            failures++;
            $display("FAIL single_pulse: got %0d want 1", vld_cyc - v0);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            failures++;
            $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0",
                     fe_cnt - f0, ov_cnt - o0);
        end
        hold(1'b1, 100);
    endtask

    task automatic test_overrun();
        int o0;
        int f0;
        int n0;
        rx_ready = 1'b0;
        o0 = ov_cnt;
        f0 = fe_cnt;
        n0 = got_q.size();
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, BT);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            failures++;
            $display("FAIL ovr_first: got v=%b d=%h want v=1 d=3c",
                     rx_valid, rx_data);
        end
        send(8'h81, 1'b1, BT);
        checks++;
        if (ov_cnt - o0 !== 1) begin
            failures++;
            $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - o0);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            failures++;
            $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=3c",
                     rx_valid, rx_data);
        end
        checks++;
        if (got_q.size() != n0 || fe_cnt != f0) begin
            failures++;
            $display("FAIL ovr_quiet: got hs=%0d fe=%0d want 0 0",
                     got_q.size() - n0, fe_cnt - f0);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got %b want 0", rx_valid);
        end
        pop_cmp("ovr");
        hold(1'b1, 100);
    endtask

    task automatic test_frame_err();
        int f0;
        int v0;
        int n0;
        f0 = fe_cnt;
        v0 = vld_cyc;
        n0 = got_q.size();
        send(8'h55, 1'b0, BT);
        hold(1'b0, 2000);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - f0);
        end
        checks++;
        if (vld_cyc != v0 || got_q.size() != n0) begin
            failures++;
            $display("FAIL ferr_novalid: got %0d cycles want 0",
                     vld_cyc - v0);
        end
        hold(1'b1, 200);
        checks++;
        if (fe_cnt - f0 !== 1 || got_q.size() != n0) begin
            failures++;
            $display("FAIL ferr_break: got fe=%0d hs=%0d want 1 0",
                     fe_cnt - f0, got_q.size() - n0);
        end
        exp_q.push_back(8'h12);
        send(8'h12, 1'b1, BT);
        pop_cmp("ferr_after");
        hold(1'b1, 100);
    endtask

    task automatic test_glitch();
        int f0;
        int o0;
        int v0;
        f0 = fe_cnt;
        o0 = ov_cnt;
        v0 = vld_cyc;
        hold(1'b0, 40);
        hold(1'b1, 300);
        checks++;
        if (vld_cyc != v0 || fe_cnt != f0 || ov_cnt != o0) begin
            failures++;
            $display("FAIL glitch_quiet: got v=%0d fe=%0d ov=%0d want 0 0 0",
                     vld_cyc - v0, fe_cnt - f0, ov_cnt - o0);
        end
        exp_q.push_back(8'hF0);
        send(8'hF0, 1'b1, BT);
        pop_cmp("glitch_after");
        hold(1'b1, 100);
    endtask

    task automatic test_reset_mid();
        int n0;
        int f0;
        int o0;
        n0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        hold(1'b0, BT);
        for (int i = 0; i < 4; i++) hold(1'b1, BT);
        hold(1'b1, BT / 2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun} !== 11'h000) begin
            failures++;
            $display("FAIL rstmid_out: got d=%h v=%b fe=%b ov=%b want 0",
                     rx_data, rx_valid, frame_err, overrun);
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        hold(1'b1, 1200);
        checks++;
        if (got_q.size() != n0 || fe_cnt != f0 || ov_cnt != o0) begin
            failures++;
            $display("FAIL rstmid_discard: got hs=%0d fe=%0d ov=%0d want 0",
                     got_q.size() - n0, fe_cnt - f0, ov_cnt - o0);
        end
        exp_q.push_back(8'h0F);
        send(8'h0F, 1'b1, BT);
        pop_cmp("rstmid_after");
        hold(1'b1, 100);
    endtask

    task automatic test_baud_skew();
        int f0;
        f0 = fe_cnt;
        exp_q.push_back(8'h69);
        send(8'h69, 1'b1, 165);
        pop_cmp("skew_slow");
        hold(1'b1, 100);
        exp_q.push_back(8'h69);
        send(8'h69, 1'b1, 155);
        pop_cmp("skew_fast");
        checks++;
        if (fe_cnt != f0) begin
            failures++;
            $display("FAIL skew_ferr: got %0d want 0", fe_cnt - f0);
        end
        hold(1'b1, 100);
    endtask

    task automatic test_final();
        checks++;
        if (fe_wide != 0 || ov_wide != 0 || both_cnt != 0) begin
            failures++;
            $display("FAIL pulse_shape: got wide_fe=%0d wide_ov=%0d both=%0d want 0",
                     fe_wide, ov_wide, both_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != rd) begin
            failures++;
            $display("FAIL scoreboard_left: got exp=%0d extra=%0d want 0 0",
                     exp_q.size(), got_q.size() - rd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_baud_skew();
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
